// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one byte-wide synchronous RAM between two word requesters.
// Each granted word is moved as four byte beats, most-significant byte at the lowest address.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [31:0]           wdata0,
  input  logic [31:0]           wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [31:0]           rdata0,
  output logic [31:0]           rdata1,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC, TAIL} state_t;

  state_t                state, state_next;
  logic [1:0]            beat, beat_next;
  logic                  grant_go;
  logic                  grant_id;
  logic                  last_q;
  logic                  port_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [23:0]           asm_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      beat  <= 2'd0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // Memory strobes are decoded from the latched transaction only, never from live requester inputs.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    grant_go   = 1'b0;
    grant_id   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_go   = 1'b1;
          grant_id   = (req0 && req1) ? ~last_q : req1;
          state_next = ACC;
          beat_next  = 2'd0;
        end
      end
      ACC: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        mem_addr = addr_q + {{(ADDR_WIDTH-2){1'b0}}, beat};
        case (beat)
          2'd0:    mem_wdata = wdata_q[31:24];
          2'd1:    mem_wdata = wdata_q[23:16];
          2'd2:    mem_wdata = wdata_q[15:8];
          default: mem_wdata = wdata_q[7:0];
        endcase
        if (beat == 2'd3) begin
          state_next = TAIL;
        end else begin
          beat_next = beat + 2'd1;
        end
      end
      TAIL: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        beat_next  = 2'd0;
      end
    endcase
  end

  // Read bytes arrive one cycle behind their beat; the last byte lands during TAIL and is
  // merged straight into the port register so rdata only changes when the read completes.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      asm_q   <= 24'h0;
      rdata0  <= 32'h0;
      rdata1  <= 32'h0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy  <= (state_next != IDLE);
      if (grant_go) begin
        port_q  <= grant_id;
        last_q  <= grant_id;
        we_q    <= grant_id ? we1 : we0;
        addr_q  <= grant_id ? addr1 : addr0;
        wdata_q <= grant_id ? wdata1 : wdata0;
        gnt0    <= ~grant_id;
        gnt1    <= grant_id;
      end
      if (state == ACC && !we_q) begin
        case (beat)
          2'd1:    asm_q[23:16] <= mem_rdata;
          2'd2:    asm_q[15:8]  <= mem_rdata;
          2'd3:    asm_q[7:0]   <= mem_rdata;
          default: asm_q        <= asm_q;
        endcase
      end
      if (state == TAIL) begin
        done0 <= ~port_q;
        done1 <= port_q;
        if (!we_q) begin
          if (port_q) begin
            rdata1 <= {asm_q, mem_rdata};
          end else begin
            rdata0 <= {asm_q, mem_rdata};
          end
        end
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single byte-wide data memory between two word-level requesters: port 0 (CPU load/store unit) and port 1 (host loader/debug access). Each granted transaction is sequenced as four byte beats, most-significant byte at the lowest address, so a 32-bit word assembles exactly as the CPU expects. Arbitration between the two ports is round-robin. The block sits between the multicycle core's MEM stage and the `D_Memory` byte array.

## Interface
- ADDR_WIDTH, 16, byte-address width for requester addresses and `mem_addr`

- CLOCK_50  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request from port 0 / port 1; level-sensitive
- we0 / we1  in  1  1 = write word, 0 = read word
- addr0 / addr1  in  ADDR_WIDTH  byte base address; need not be aligned
- wdata0 / wdata1  in  32  write word
- gnt0 / gnt1  out  1  one-cycle pulse when the request is latched
- done0 / done1  out  1  one-cycle pulse when the transaction completes
- rdata0 / rdata1  out  32  read word; valid from `done` and held until that port's next read completes
- busy  out  1  high whenever state ≠ IDLE
- mem_en  out  1  byte access strobe
- mem_we  out  1  byte write enable; only meaningful with `mem_en`
- mem_addr  out  ADDR_WIDTH  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid the cycle after the `mem_en` read beat (1-cycle synchronous RAM)

## Operation
- States:
  - IDLE → ACC: when any `req` is high at a clock edge.
  - ACC: 4 beats; `beat` counts 0..3. → TAIL after beat 3.
  - TAIL → IDLE: unconditional.
- Arbitration, in IDLE only:
  - One request high: grant it.
  - Both high: grant the port not served last.
  - The last-served pointer resets to "port 1", so port 0 wins first after reset.
- On grant, latch port id, `we`, `addr`, and `wdata`. Requester inputs are ignored outside IDLE.
- ACC beat k:
  - `mem_en`=1, `mem_addr` = base + k, modulo 2^ADDR_WIDTH (wraps at the top).
  - `mem_we` = latched `we`.
  - `mem_wdata` = wdata[31-8k : 24-8k].
- Reads: the byte returned for beat k is captured into bits [31-8k : 24-8k] of the port's `rdata` register. No sign extension or byte modification.
- Writes and reads follow identical timing (uniform latency).
- `req` is interpreted in every IDLE cycle, including the cycle `done` is high. A requester wanting exactly one transaction must drop `req` by the cycle after `gnt`.
- Reset (async) forces:
  - state = IDLE, beat = 0, last-served = 1.
  - `gnt*`, `done*`, `busy`, `mem_en`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `rdata*` = 0.
- Reset mid-transaction aborts it: no `done`; bytes already written stay written.

## Timing
- C0: IDLE, `req` sampled high.
- C1: `gnt` pulse, beat 0.
- C2–C4: beats 1–3.
- C5: TAIL, `mem_en`=0; read byte 3 captured at the end of C5.
- C6: `done` pulse, `rdata` valid, state IDLE; a new grant can be decided at the end of C6.
- Latency: 6 cycles request-to-done. Throughput: one word per 6 cycles.
- `gnt0`/`gnt1` are never high together, and neither are `done0`/`done1`.
- `busy` is high C1–C5.
- All outputs are registered except `mem_addr`, `mem_we`, `mem_wdata`, and `mem_en`. These are decoded from registered state only, with no combinational path from `req`/`addr`.

## Test plan
- **Port 0 write:** write `addr0`=0x0010, `wdata0`=0x11223344 → beats C1–C4 write 0x11@0x10, 0x22@0x11, 0x33@0x12, 0x44@0x13; `done0` in C6. Then read 0x0010 → `rdata0`=0x11223344 in that read's C6.
- **Simultaneous first requests:** `req0` and `req1` both rise in the first cycle after reset → `gnt0` in C1, `done0` in C6, `gnt1` in C7, `done1` in C12.
- **Sustained contention:** both requests held high for 4 transactions → grants alternate 0, 1, 0, 1; each `gnt` is exactly 6 cycles after the previous one.
- **Address wrap:** ADDR_WIDTH=16, read `addr1`=0xFFFE over bytes 0xAA, 0xBB, 0xCC, 0xDD at 0xFFFE, 0xFFFF, 0x0000, 0x0001 → `mem_addr` sequence FFFE, FFFF, 0000, 0001; `rdata1`=0xAABBCCDD.
- **No sign extension:** read of bytes 0x80, 0xFF, 0x00, 0x01 → `rdata0`=0x80FF0001 exactly.
- **Reset mid-write:** assert `reset` during C3 of a write of 0xDEADBEEF to 0x0020 → all outputs 0 immediately; only 0xDE@0x20 and 0xAD@0x21 written; no `done`. The next request is granted normally, to port 0 first.
